// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter: 4 request channels share one binary-to-BCD converter. Optional clamp feature: BCD_ARB_CLAMP_EN.
// Latency: gnt/conv_start 1 cycle after the IDLE grant decision; res_valid 1 cycle after conv_done, or after TIMEOUT WAIT cycles.
// Backpressure: a channel holds req and operand until its gnt; only one conversion is in flight, so other requesters wait.
module bcd_conv_arbiter #(
    parameter int TIMEOUT = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [55:0] bin_in,
    output logic [3:0]  gnt,
    output logic        conv_start,
    output logic [13:0] conv_bin,
    input  logic [15:0] conv_bcd,
    input  logic        conv_done,
    output logic        res_valid,
    output logic [15:0] res_bcd,
    output logic [1:0]  res_ch,
    output logic        res_err,
    output logic        res_ovf,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, START, WAIT, OUT} state_t;

    state_t      state;
    logic [1:0]  ptr;
    logic [1:0]  ch;
    logic [7:0]  wcnt;
    logic [1:0]  pick;
    logic [13:0] op;
    logic [13:0] op_cap;
`ifdef BCD_ARB_CLAMP_EN
    logic        ovf_cap;
    logic        ovf_lat;
`endif

    // Walk the search order backwards so the last hit is the one closest to ptr.
    always_comb begin
        pick = ptr;
        for (int i = 3; i >= 0; i--) begin
            if (req[ptr + 2'(i)]) pick = ptr + 2'(i);
        end
    end

    always_comb begin
        case (pick)
            2'd0:    op = bin_in[13:0];
            2'd1:    op = bin_in[27:14];
            2'd2:    op = bin_in[41:28];
            default: op = bin_in[55:42];
        endcase
    end

`ifdef BCD_ARB_CLAMP_EN
    always_comb begin
        ovf_cap = (op > 14'd9999);
        op_cap  = ovf_cap ? 14'd9999 : op;
    end
`else
    assign op_cap  = op;
    assign res_ovf = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            ptr        <= 2'd0;
            ch         <= 2'd0;
            wcnt       <= 8'd0;
            gnt        <= 4'd0;
            conv_start <= 1'b0;
            conv_bin   <= 14'd0;
            res_valid  <= 1'b0;
            res_bcd    <= 16'd0;
            res_ch     <= 2'd0;
            res_err    <= 1'b0;
            busy       <= 1'b0;
`ifdef BCD_ARB_CLAMP_EN
            res_ovf    <= 1'b0;
            ovf_lat    <= 1'b0;
`endif
        end else begin
            gnt        <= 4'd0;
            conv_start <= 1'b0;
            res_valid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt        <= 4'b0001 << pick;
                        conv_start <= 1'b1;
                        conv_bin   <= op_cap;
                        ch         <= pick;
                        ptr        <= pick + 2'd1;
                        busy       <= 1'b1;
                        state      <= START;
`ifdef BCD_ARB_CLAMP_EN
                        ovf_lat    <= ovf_cap;
`endif
                    end
                end
                START: begin
                    wcnt  <= 8'd0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (conv_done) begin
                        res_bcd   <= conv_bcd;
                        res_err   <= 1'b0;
                        res_valid <= 1'b1;
                        res_ch    <= ch;
                        state     <= OUT;
`ifdef BCD_ARB_CLAMP_EN
                        res_ovf   <= ovf_lat;
`endif
                    end else if (wcnt == 8'(TIMEOUT - 1)) begin
                        // Converter never answered: abandon with a zero result.
                        res_bcd   <= 16'd0;
                        res_err   <= 1'b1;
                        res_valid <= 1'b1;
                        res_ch    <= ch;
                        state     <= OUT;
`ifdef BCD_ARB_CLAMP_EN
                        res_ovf   <= ovf_lat;
`endif
                    end else begin
                        wcnt <= wcnt + 8'd1;
                    end
                end
                default: begin
                    res_err <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
`ifdef BCD_ARB_CLAMP_EN
                    res_ovf <= 1'b0;
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed bench for bcd_conv_arbiter with a latency-configurable converter model and grant/result scoreboards.
module tb_bcd_conv_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req = 4'd0;
    logic [55:0] bin_in = 56'd0;
    logic [3:0]  gnt;
    logic        conv_start;
    logic [13:0] conv_bin;
    logic [15:0] conv_bcd = 16'd0;
    logic        conv_done;
    logic        res_valid;
    logic [15:0] res_bcd;
    logic [1:0]  res_ch;
    logic        res_err;
    logic        res_ovf;
    logic        busy;

    bcd_conv_arbiter #(.TIMEOUT(32)) dut (
        .clk(clk), .rst(rst), .req(req), .bin_in(bin_in), .gnt(gnt),
        .conv_start(conv_start), .conv_bin(conv_bin), .conv_bcd(conv_bcd),
        .conv_done(conv_done), .res_valid(res_valid), .res_bcd(res_bcd),
        .res_ch(res_ch), .res_err(res_err), .res_ovf(res_ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {logic [1:0] ch; logic [13:0] bin;} g_t;
    typedef struct {logic [1:0] ch; logic [15:0] bcd; logic err; logic ovf;} r_t;
    g_t gq[$];
    r_t rq[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int gcnt = 0;
    int t_st = 0;
    int t_rv = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] bcd4(input int v);
        int w;
        w = v % 10000;
        return {4'(w / 1000), 4'((w / 100) % 10), 4'((w / 10) % 10), 4'(w % 10)};
    endfunction

    // Converter model
    logic mdl_en = 1'b1;
    logic mdl_done = 1'b0;
    logic frc_done = 1'b0;
    int   mdl_lat = 15;
    assign conv_done = mdl_done | frc_done;

    initial begin
        bit pend;
        int lat;
        int mop;
        pend = 0; lat = 0; mop = 0;
        forever begin
            @(negedge clk);
            mdl_done = 1'b0;
            if (!rst) pend = 0;
            else if (mdl_en && conv_start) begin
                pend = 1; lat = mdl_lat; mop = int'(conv_bin);
            end else if (pend) begin
                lat--;
                if (lat == 0) begin
                    pend = 0; mdl_done = 1'b1; conv_bcd = bcd4(mop);
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor
    initial begin
        logic prev_gnt;
        logic prev_rv;
        g_t g;
        r_t r;
        prev_gnt = 1'b0; prev_rv = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_gnt) chk("gnt_pulse", {28'd0, gnt}, 32'd0);
            if (prev_rv) chk("busy_after_out", {31'd0, busy}, 32'd0);
            if (gnt != 4'd0 || conv_start) begin
                if (gq.size() == 0) chk("gnt_unexp", {28'd0, gnt}, 32'd0);
                else begin
                    g = gq.pop_front();
                    chk("gnt", {28'd0, gnt}, 32'd1 << g.ch);
                    chk("conv_start", {31'd0, conv_start}, 32'd1);
                    chk("conv_bin", {18'd0, conv_bin}, {18'd0, g.bin});
                    t_st = cyc;
                    gcnt++;
                end
            end
            if (res_valid) begin
                if (rq.size() == 0) chk("res_unexp", {31'd0, res_valid}, 32'd0);
                else begin
                    r = rq.pop_front();
                    chk("res_ch", {30'd0, res_ch}, {30'd0, r.ch});
                    chk("res_bcd", {16'd0, res_bcd}, {16'd0, r.bcd});
                    chk("res_err", {31'd0, res_err}, {31'd0, r.err});
                    chk("res_ovf", {31'd0, res_ovf}, {31'd0, r.ovf});
                    t_rv = cyc;
                end
            end
            prev_gnt = (gnt != 4'd0);
            prev_rv  = res_valid;
        end
    end

    task automatic push_g(input logic [1:0] c, input logic [13:0] b);
        g_t g;
        g.ch = c; g.bin = b;
        gq.push_back(g);
    endtask

    task automatic push_r(input logic [1:0] c, input logic [15:0] d, input logic e, input logic o);
        r_t r;
        r.ch = c; r.bcd = d; r.err = e; r.ovf = o;
        rq.push_back(r);
    endtask

    task automatic wait_gnt(input int n, input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (gcnt >= n) ok = 1;
        end
        chk("wait_gnt", {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (gq.size() == 0 && rq.size() == 0 && !busy) ok = 1;
        end
        chk(tag, {31'd0, ok}, 32'd1);
    endtask

    logic out_zero;
    assign out_zero = (gnt == 4'd0) && !conv_start && (conv_bin == 14'd0) && !res_valid &&
                      (res_bcd == 16'd0) && (res_ch == 2'd0) && !res_err && !res_ovf && !busy;

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_outputs", {31'd0, out_zero}, 32'd1);
        rst = 1'b1;
        @(negedge clk);

        // Single request on ch2
        gcnt = 0;
        bin_in = {14'd0, 14'd1234, 14'd0, 14'd0};
        push_g(2'd2, 14'd1234);
        push_r(2'd2, 16'h1234, 1'b0, 1'b0);
        req = 4'b0100;
        wait_gnt(1, 50);
        req = 4'b0000;
        repeat (3) @(negedge clk);
        // Short-lived request that vanishes before the arbiter is free again
        req = 4'b0010;
        repeat (3) @(negedge clk);
        req = 4'b0000;
        wait_idle("single_drain", 100);
        repeat (3) @(negedge clk);

        // Fairness with all channels requesting (ptr is 3 after ch2)
        gcnt = 0;
        bin_in = {14'd4444, 14'd333, 14'd22, 14'd1};
        push_g(2'd3, 14'd4444); push_r(2'd3, 16'h4444, 1'b0, 1'b0);
        push_g(2'd0, 14'd1);    push_r(2'd0, 16'h0001, 1'b0, 1'b0);
        push_g(2'd1, 14'd22);   push_r(2'd1, 16'h0022, 1'b0, 1'b0);
        push_g(2'd2, 14'd333);  push_r(2'd2, 16'h0333, 1'b0, 1'b0);
        push_g(2'd3, 14'd4444); push_r(2'd3, 16'h4444, 1'b0, 1'b0);
        req = 4'b1111;
        wait_gnt(5, 400);
        req = 4'b0000;
        wait_idle("fair_drain", 100);

        // Timeout: converter silent; ptr is 0 now
        gcnt = 0;
        mdl_en = 1'b0;
        bin_in = {14'd0, 14'd0, 14'd50, 14'd0};
        push_g(2'd1, 14'd50);
        push_r(2'd1, 16'h0000, 1'b1, 1'b0);
        req = 4'b0010;
        wait_gnt(1, 50);
        req = 4'b0000;
        wait_idle("timeout_drain", 100);
        chk("timeout_latency", 32'(t_rv - t_st), 32'd33);
        mdl_en = 1'b1;

        // Clamp on ch1
        gcnt = 0;
        bin_in = {14'd0, 14'd0, 14'd12000, 14'd0};
`ifdef BCD_ARB_CLAMP_EN
        push_g(2'd1, 14'd9999);
        push_r(2'd1, 16'h9999, 1'b0, 1'b1);
`else
        push_g(2'd1, 14'd12000);
        push_r(2'd1, 16'h2000, 1'b0, 1'b0);
`endif
        req = 4'b0010;
        wait_gnt(1, 50);
        req = 4'b0000;
        wait_idle("clamp_drain", 100);

        // Reset in WAIT, then a stray conv_done in IDLE
        gcnt = 0;
        mdl_en = 1'b0;
        bin_in = {14'd0, 14'd0, 14'd0, 14'd100};
        push_g(2'd0, 14'd100);
        req = 4'b0001;
        wait_gnt(1, 50);
        req = 4'b0000;
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1 chk("reset_in_wait", {31'd0, out_zero}, 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        frc_done = 1'b1;
        @(negedge clk);
        frc_done = 1'b0;
        repeat (5) @(negedge clk);
        chk("after_stray_done", {31'd0, out_zero}, 32'd1);
        mdl_en = 1'b1;

        gcnt = 0;
        bin_in = {14'd7, 14'd0, 14'd0, 14'd0};
        push_g(2'd3, 14'd7);
        push_r(2'd3, 16'h0007, 1'b0, 1'b0);
        req = 4'b1000;
        wait_gnt(1, 50);
        req = 4'b0000;
        wait_idle("post_reset_drain", 100);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
